// File: rtl/vector_checker_pkg.sv
// Shared types and helpers for the vector_checker response checker.
package vector_checker_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Increment that sticks at max_value instead of wrapping.
  function automatic logic [63:0] sat_inc(input logic [63:0] value,
                                          input logic [63:0] max_value);
    return (value == max_value) ? value : value + 64'd1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear takes priority over increment.
module sat_counter
  import vector_checker_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  localparam logic [63:0] MaxValue = 64'({CNT_WIDTH{1'b1}});

  logic [CNT_WIDTH-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      count_d = CNT_WIDTH'(sat_inc(64'(count_q), MaxValue));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/vector_checker.sv
// Response checker: compares (dut_y, exp_y) pairs per handshake, counts vectors/errors.
// Optional first-mismatch capture enabled by VECTOR_CHECKER_FIRST_ERR_EN.
module vector_checker
  import vector_checker_pkg::*;
#(
  parameter int unsigned WIDTH     = 1,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 vec_valid,
  output logic                 vec_ready,
  input  logic                 vec_last,
  input  logic [WIDTH-1:0]     dut_y,
  input  logic [WIDTH-1:0]     exp_y,
  output logic                 err_pulse,
  output logic [CNT_WIDTH-1:0] vector_count,
  output logic [CNT_WIDTH-1:0] error_count,
  output logic                 busy,
  output logic                 done,
`ifdef VECTOR_CHECKER_FIRST_ERR_EN
  output logic                 first_err_valid,
  output logic [CNT_WIDTH-1:0] first_err_index,
  output logic [WIDTH-1:0]     first_err_dut,
  output logic [WIDTH-1:0]     first_err_exp,
`endif
  output logic                 pass
);

  state_e state_q, state_d;
  logic   transfer, mismatch;
  logic   err_pulse_q, pass_q;

  // A start on the same edge as a handshake discards that pair.
  assign transfer = vec_valid && vec_ready && !start;
  assign mismatch = transfer && (dut_y != exp_y);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (start) state_d = RUN;
               else if (transfer && vec_last) state_d = DONE;
      DONE:    if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    vec_ready = (state_q == RUN);
    busy      = (state_q == RUN);
    done      = (state_q == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_pulse_q <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      err_pulse_q <= mismatch;
      if (start) begin
        pass_q <= 1'b0;
      end else if (transfer && vec_last) begin
        // Fold in the final pair, whose error increment lands on this same edge.
        pass_q <= (error_count == '0) && !mismatch;
      end
    end
  end

  assign err_pulse = err_pulse_q;
  assign pass      = pass_q;

  sat_counter #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_vec_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (start),
    .inc  (transfer),
    .count(vector_count)
  );

  sat_counter #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_err_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (start),
    .inc  (mismatch),
    .count(error_count)
  );

`ifdef VECTOR_CHECKER_FIRST_ERR_EN
  logic                 first_valid_q;
  logic [CNT_WIDTH-1:0] first_index_q;
  logic [WIDTH-1:0]     first_dut_q, first_exp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_valid_q <= 1'b0;
      first_index_q <= '0;
      first_dut_q   <= '0;
      first_exp_q   <= '0;
    end else if (start) begin
      first_valid_q <= 1'b0;
      first_index_q <= '0;
      first_dut_q   <= '0;
      first_exp_q   <= '0;
    end else if (mismatch && !first_valid_q) begin
      first_valid_q <= 1'b1;
      first_index_q <= vector_count;
      first_dut_q   <= dut_y;
      first_exp_q   <= exp_y;
    end
  end

  assign first_err_valid = first_valid_q;
  assign first_err_index = first_index_q;
  assign first_err_dut   = first_dut_q;
  assign first_err_exp   = first_exp_q;
`endif

endmodule

// File: tb/tb_vector_checker.sv
// Directed bench for vector_checker with an err_pulse scoreboard; covers
// VECTOR_CHECKER_FIRST_ERR_EN outputs when that macro is defined.
module tb_vector_checker;

  localparam int unsigned W   = 1;
  localparam int unsigned CW  = 32;
  localparam int unsigned SCW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic          start = 1'b0, vec_valid = 1'b0, vec_last = 1'b0;
  logic [W-1:0]  dut_y = '0, exp_y = '0;
  logic          vec_ready, err_pulse, busy, done, pass;
  logic [CW-1:0] vector_count, error_count;

  logic           s_start = 1'b0, s_valid = 1'b0, s_last = 1'b0;
  logic [W-1:0]   s_dut = '0, s_exp = '0;
  logic           s_ready, s_err_pulse, s_busy, s_done, s_pass;
  logic [SCW-1:0] s_vector_count, s_error_count;

`ifdef VECTOR_CHECKER_FIRST_ERR_EN
  logic           fe_valid, s_fe_valid;
  logic [CW-1:0]  fe_index;
  logic [SCW-1:0] s_fe_index;
  logic [W-1:0]   fe_dut, fe_exp, s_fe_dut, s_fe_exp;
`endif

  int          checks = 0;
  int          failures = 0;
  int          pulse_cnt = 0;
  int          s_pulse_cnt = 0;
  int          p0;
  bit          exp_q[$];
  logic [63:0] exp_vc, exp_ec;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (err_pulse === 1'b1) pulse_cnt <= pulse_cnt + 1;
    if (s_err_pulse === 1'b1) s_pulse_cnt <= s_pulse_cnt + 1;
  end

  vector_checker #(
    .WIDTH(W),
    .CNT_WIDTH(CW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .vec_valid      (vec_valid),
    .vec_ready      (vec_ready),
    .vec_last       (vec_last),
    .dut_y          (dut_y),
    .exp_y          (exp_y),
    .err_pulse      (err_pulse),
    .vector_count   (vector_count),
    .error_count    (error_count),
    .busy           (busy),
    .done           (done),
`ifdef VECTOR_CHECKER_FIRST_ERR_EN
    .first_err_valid(fe_valid),
    .first_err_index(fe_index),
    .first_err_dut  (fe_dut),
    .first_err_exp  (fe_exp),
`endif
    .pass           (pass)
  );

  vector_checker #(
    .WIDTH(W),
    .CNT_WIDTH(SCW)
  ) dut_sat (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (s_start),
    .vec_valid      (s_valid),
    .vec_ready      (s_ready),
    .vec_last       (s_last),
    .dut_y          (s_dut),
    .exp_y          (s_exp),
    .err_pulse      (s_err_pulse),
    .vector_count   (s_vector_count),
    .error_count    (s_error_count),
    .busy           (s_busy),
    .done           (s_done),
`ifdef VECTOR_CHECKER_FIRST_ERR_EN
    .first_err_valid(s_fe_valid),
    .first_err_index(s_fe_index),
    .first_err_dut  (s_fe_dut),
    .first_err_exp  (s_fe_exp),
`endif
    .pass           (s_pass)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_vc = '0;
    exp_ec = '0;
    exp_q.delete();
  endtask

  // One handshake; the expected strobe is queued at the edge and compared a cycle later.
  task automatic xfer(input logic d, input logic e, input logic last);
    vec_valid = 1'b1;
    dut_y     = d;
    exp_y     = e;
    vec_last  = last;
    @(posedge clk);
    exp_q.push_back(d != e);
    exp_vc = exp_vc + 64'd1;
    if (d != e) exp_ec = exp_ec + 64'd1;
    #1;
    check("err_pulse", 64'(err_pulse), 64'(exp_q.pop_front()));
    check("vector_count", 64'(vector_count), exp_vc);
    check("error_count", 64'(error_count), exp_ec);
    vec_valid = 1'b0;
    vec_last  = 1'b0;
  endtask

  initial begin
    bit       pat[5];
    logic [1:0] ab;
    logic     y;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_vc = '0;
    exp_ec = '0;

    // Reset and idle
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_vec_ready", 64'(vec_ready), 64'd0);
    rst_n = 1'b1;
    tick();
    check("idle_vec_ready", 64'(vec_ready), 64'd0);
    check("idle_done", 64'(done), 64'd0);
    check("idle_pass", 64'(pass), 64'd0);
    check("idle_err_pulse", 64'(err_pulse), 64'd0);
    check("idle_error_count", 64'(error_count), 64'd0);
    vec_valid = 1'b1;
    dut_y = 1'b1;
    exp_y = 1'b0;
    repeat (3) tick();
    vec_valid = 1'b0;
    check("idle_no_count", 64'(vector_count), 64'd0);
    check("idle_no_err", 64'(error_count), 64'd0);

    // Clean OR2 run
    p0 = pulse_cnt;
    do_start();
    check("run_busy", 64'(busy), 64'd1);
    check("run_vec_ready", 64'(vec_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      ab = 2'(i);
      y  = (i != 0);
      xfer(ab[1] | ab[0], y, i == 3);
    end
    check("clean_done", 64'(done), 64'd1);
    check("clean_pass", 64'(pass), 64'd1);
    check("clean_busy", 64'(busy), 64'd0);
    check("clean_vec_ready", 64'(vec_ready), 64'd0);
    tick();
    check("clean_pulses", 64'(pulse_cnt - p0), 64'd0);

    // Injected errors on vectors 2 and 3
    p0 = pulse_cnt;
    do_start();
    check("restart_done", 64'(done), 64'd0);
    check("restart_pass", 64'(pass), 64'd0);
    check("restart_busy", 64'(busy), 64'd1);
    for (int i = 0; i < 4; i++) begin
      ab = 2'(i);
      y  = (i != 0);
      xfer((i == 1 || i == 2) ? 1'b0 : (ab[1] | ab[0]), y, i == 3);
    end
    tick();
    check("err_error_count", 64'(error_count), 64'd2);
    check("err_done", 64'(done), 64'd1);
    check("err_pass", 64'(pass), 64'd0);
    check("err_pulses", 64'(pulse_cnt - p0), 64'd2);
`ifdef VECTOR_CHECKER_FIRST_ERR_EN
    check("first_valid", 64'(fe_valid), 64'd1);
    check("first_index", 64'(fe_index), 64'd1);
    check("first_dut", 64'(fe_dut), 64'd0);
    check("first_exp", 64'(fe_exp), 64'd1);
`endif

    // Back-pressure gaps
    do_start();
    for (int i = 0; i < 5; i++) begin
      vec_valid = pat[i];
      dut_y = 1'b0;
      exp_y = 1'b0;
      @(posedge clk);
      if (pat[i]) exp_vc = exp_vc + 64'd1;
      #1;
      check("gap_vector_count", 64'(vector_count), exp_vc);
    end
    vec_valid = 1'b0;
    check("gap_total", 64'(vector_count), 64'd3);

    // Restart mid-run; the pair on the start edge is discarded
    do_start();
    xfer(1'b1, 1'b0, 1'b0);
    xfer(1'b0, 1'b0, 1'b0);
    start = 1'b1;
    vec_valid = 1'b1;
    dut_y = 1'b1;
    exp_y = 1'b0;
    tick();
    start = 1'b0;
    vec_valid = 1'b0;
    check("rs_vector_count", 64'(vector_count), 64'd0);
    check("rs_error_count", 64'(error_count), 64'd0);
    check("rs_busy", 64'(busy), 64'd1);
    check("rs_err_pulse", 64'(err_pulse), 64'd0);
`ifdef VECTOR_CHECKER_FIRST_ERR_EN
    check("rs_first_valid", 64'(fe_valid), 64'd0);
`endif

    // Asynchronous reset mid-run
    exp_vc = '0;
    exp_ec = '0;
    exp_q.delete();
    xfer(1'b1, 1'b0, 1'b0);
    vec_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_vector_count", 64'(vector_count), 64'd0);
    check("ar_error_count", 64'(error_count), 64'd0);
    check("ar_busy", 64'(busy), 64'd0);
    check("ar_done", 64'(done), 64'd0);
    check("ar_err_pulse", 64'(err_pulse), 64'd0);
    #10;
    rst_n = 1'b1;
    tick();
    vec_valid = 1'b0;
    check("ar_idle_busy", 64'(busy), 64'd0);
    check("ar_idle_count", 64'(vector_count), 64'd0);

    // Saturation on the narrow-counter instance
    p0 = s_pulse_cnt;
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      s_valid = 1'b1;
      s_dut = 1'b1;
      s_exp = 1'b0;
      tick();
    end
    s_valid = 1'b0;
    tick();
    tick();
    check("sat_error_count", 64'(s_error_count), 64'd7);
    check("sat_vector_count", 64'(s_vector_count), 64'd7);
    check("sat_pulses", 64'(s_pulse_cnt - p0), 64'd10);
    check("sat_busy", 64'(s_busy), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
